// File: rtl/bus_transaction_unit_pkg.sv
// bus_transaction_unit_pkg: transaction codes and bus-unit states/lane-enable constants
package transactionGroup;
  typedef enum logic [3:0] {
    NO_OP, READ, WRITE_BYTE0, WRITE_BYTE1, WRITE_BYTE2, WRITE_BYTE3,
    WRITE_WORD0, WRITE_WORD1, WRITE_DWORD
  } controlBus;
endpackage

package busUnitPkg;
  typedef enum logic {IDLE, ACCESS} busStates;
  localparam logic [3:0] BE_NONE  = 4'b0000;
  localparam logic [3:0] BE_READ  = 4'b1111;
  localparam logic [3:0] BE_BYTE0 = 4'b0001;
  localparam logic [3:0] BE_BYTE1 = 4'b0010;
  localparam logic [3:0] BE_BYTE2 = 4'b0100;
  localparam logic [3:0] BE_BYTE3 = 4'b1000;
  localparam logic [3:0] BE_WORD0 = 4'b0011;
  localparam logic [3:0] BE_WORD1 = 4'b1100;
  localparam logic [3:0] BE_DWORD = 4'b1111;
endpackage

// File: rtl/bus_transaction_unit_decoder.sv
// transaction_lane_decoder: maps a transaction code to lane enables, steered store data and access kind
module transaction_lane_decoder
  import transactionGroup::*;
  import busUnitPkg::*;
(
  input  transactionGroup::controlBus transactionControl,
  input  logic [31:0]                 writeData,
  output logic [3:0]                  byteEnable,
  output logic [31:0]                 steeredData,
  output logic                        isRead,
  output logic                        isWrite
);
  logic w_byte;
  logic w_word;
  assign w_byte = transactionControl inside {WRITE_BYTE0, WRITE_BYTE1, WRITE_BYTE2, WRITE_BYTE3};
  assign w_word = transactionControl inside {WRITE_WORD0, WRITE_WORD1};
  assign steeredData = w_byte ? {4{writeData[7:0]}} : w_word ? {2{writeData[15:0]}} : writeData;
  always_comb begin
    byteEnable = BE_NONE;
    isRead = 1'b0;
    isWrite = 1'b1;
    case (transactionControl)
      READ: begin
        byteEnable = BE_READ;
        isRead = 1'b1;
        isWrite = 1'b0;
      end
      WRITE_BYTE0: byteEnable = BE_BYTE0;
      WRITE_BYTE1: byteEnable = BE_BYTE1;
      WRITE_BYTE2: byteEnable = BE_BYTE2;
      WRITE_BYTE3: byteEnable = BE_BYTE3;
      WRITE_WORD0: byteEnable = BE_WORD0;
      WRITE_WORD1: byteEnable = BE_WORD1;
      WRITE_DWORD: byteEnable = BE_DWORD;
      default: isWrite = 1'b0;
    endcase
  end
endmodule

// File: rtl/bus_transaction_unit.sv
// bus_transaction_unit: runs one controller memory transaction on the req/ack memory bus,
// stalling the controller for the access and aborting it after TIMEOUT_CYCLES without ack.
module bus_transaction_unit
  import transactionGroup::*;
  import busUnitPkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                        clk,
  input  logic                        reset,
  input  transactionGroup::controlBus transactionControl,
  input  logic [31:0]                 address,
  input  logic [31:0]                 writeData,
  output logic                        stall,
  output logic [31:0]                 readData,
  output logic                        busError,
  output logic [29:0]                 memAddress,
  output logic [3:0]                  memByteEnable,
  output logic [31:0]                 memWriteData,
  output logic                        memRead,
  output logic                        memWrite,
  input  logic [31:0]                 memReadData,
  input  logic                        memAck
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  busStates    r_state;
  logic [CW-1:0] r_count;
  logic [31:0] r_readData;
  logic        r_busError;
  logic [29:0] r_memAddress;
  logic [3:0]  r_memByteEnable;
  logic [31:0] r_memWriteData;
  logic        r_memRead;
  logic        r_memWrite;
  logic [3:0]  w_be;
  logic [31:0] w_data;
  logic        w_isRead;
  logic        w_isWrite;
  logic        w_req;
  logic        w_timeout;
  logic        w_unused;
  transaction_lane_decoder u_decoder (
    .transactionControl(transactionControl),
    .writeData         (writeData),
    .byteEnable        (w_be),
    .steeredData       (w_data),
    .isRead            (w_isRead),
    .isWrite           (w_isWrite)
  );
  assign w_unused  = ^address[1:0];
  assign w_req     = w_isRead | w_isWrite;
  // r_count holds the ack-less cycles already spent, so the current one is the last allowed
  assign w_timeout = !memAck && (r_count == CW'(TIMEOUT_CYCLES - 1));
  assign stall     = (r_state == IDLE) ? w_req : !(memAck || w_timeout);
  assign readData      = r_readData;
  assign busError      = r_busError;
  assign memAddress    = r_memAddress;
  assign memByteEnable = r_memByteEnable;
  assign memWriteData  = r_memWriteData;
  assign memRead       = r_memRead;
  assign memWrite      = r_memWrite;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state         <= IDLE;
      r_count         <= '0;
      r_readData      <= '0;
      r_busError      <= 1'b0;
      r_memAddress    <= '0;
      r_memByteEnable <= '0;
      r_memWriteData  <= '0;
      r_memRead       <= 1'b0;
      r_memWrite      <= 1'b0;
    end else begin
      r_busError <= 1'b0;
      case (r_state)
        IDLE: if (w_req) begin
          r_state         <= ACCESS;
          r_count         <= '0;
          r_memAddress    <= address[31:2];
          r_memByteEnable <= w_be;
          r_memWriteData  <= w_data;
          r_memRead       <= w_isRead;
          r_memWrite      <= w_isWrite;
        end
        ACCESS: if (memAck) begin
          r_state    <= IDLE;
          r_memRead  <= 1'b0;
          r_memWrite <= 1'b0;
          if (r_memRead) r_readData <= memReadData;
        end else if (w_timeout) begin
          r_state    <= IDLE;
          r_memRead  <= 1'b0;
          r_memWrite <= 1'b0;
          r_busError <= 1'b1;
          if (r_memRead) r_readData <= '0;
        end else begin
          r_count <= r_count + 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bus_transaction_unit.sv
// tb_bus_transaction_unit: directed checks of bus_transaction_unit with TIMEOUT_CYCLES=4
module tb_bus_transaction_unit;
  import transactionGroup::*;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  controlBus   transactionControl = NO_OP;
  logic [31:0] address = '0;
  logic [31:0] writeData = '0;
  logic        stall;
  logic [31:0] readData;
  logic        busError;
  logic [29:0] memAddress;
  logic [3:0]  memByteEnable;
  logic [31:0] memWriteData;
  logic        memRead;
  logic        memWrite;
  logic [31:0] memReadData = '0;
  logic        memAck = 1'b0;
  int n_chk = 0;
  int n_pass = 0;
  int stalls, strb;
  logic [3:0]  be;
  logic [31:0] wdat;
  logic [29:0] ma;

  bus_transaction_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .transactionControl(transactionControl),
    .address(address), .writeData(writeData), .stall(stall), .readData(readData),
    .busError(busError), .memAddress(memAddress), .memByteEnable(memByteEnable),
    .memWriteData(memWriteData), .memRead(memRead), .memWrite(memWrite),
    .memReadData(memReadData), .memAck(memAck)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Presents one request, acks after `waits` ACCESS cycles, and returns once back in IDLE.
  task automatic xact(input controlBus c, input logic [31:0] a, input logic [31:0] wd,
                      input logic [31:0] rdata, input int waits, output int n_stall,
                      output int n_strb, output logic [3:0] o_be, output logic [31:0] o_wd,
                      output logic [29:0] o_ma);
    int k = 0;
    bit done = 0;
    transactionControl = c;
    address = a;
    writeData = wd;
    memReadData = rdata;
    n_stall = 0;
    n_strb = 0;
    o_be = 'x;
    o_wd = 'x;
    o_ma = 'x;
    #1 if (stall) n_stall++;
    while (!done && k < 20) begin
      tick();
      memAck = (k == waits);
      if (k == 0) begin
        o_be = memByteEnable;
        o_wd = memWriteData;
        o_ma = memAddress;
      end
      if (memRead || memWrite) n_strb++;
      #1 if (stall) n_stall++; else done = 1;
      k++;
    end
    chk("access_bound", 32'(done), 32'd1);
    transactionControl = NO_OP;
    tick();
    memAck = 1'b0;
  endtask

  initial begin
    #2;
    chk("rst_readData", readData, 32'h0);
    chk("rst_strobes", {30'd0, memRead, memWrite}, 32'h0);
    chk("rst_be_addr", {memByteEnable, memAddress[27:0]}, 32'h0);
    chk("rst_wdata", memWriteData, 32'h0);
    chk("rst_busError", 32'(busError), 32'h0);
    chk("rst_stall", 32'(stall), 32'h0);
    tick();
    reset = 1'b0;
    tick();

    xact(READ, 32'h0000_1004, 32'h0, 32'hDEAD_BEEF, 0, stalls, strb, be, wdat, ma);
    chk("rd_addr", 32'(ma), 32'h401);
    chk("rd_be", 32'(be), 32'hF);
    chk("rd_stall", 32'(stalls), 32'd1);
    chk("rd_strobe", 32'(strb), 32'd1);
    chk("rd_data", readData, 32'hDEAD_BEEF);
    chk("rd_strobe_low", 32'(memRead), 32'h0);

    xact(WRITE_BYTE2, 32'h0000_0040, 32'h0000_00A5, 32'h0, 0, stalls, strb, be, wdat, ma);
    chk("wb2_be", 32'(be), 32'h4);
    chk("wb2_data", wdat, 32'hA5A5_A5A5);
    chk("wb2_pulse", 32'(strb), 32'd1);
    chk("wb2_wr_low", 32'(memWrite), 32'h0);
    chk("wb2_rd_keep", readData, 32'hDEAD_BEEF);

    xact(WRITE_WORD1, 32'h0000_0082, 32'h0000_1234, 32'h0, 3, stalls, strb, be, wdat, ma);
    chk("ww1_be", 32'(be), 32'hC);
    chk("ww1_data", wdat, 32'h1234_1234);
    chk("ww1_stall", 32'(stalls), 32'd4);
    chk("ww1_strobe", 32'(strb), 32'd4);
    chk("ww1_ack_wins", 32'(busError), 32'h0);

    xact(READ, 32'h0000_0100, 32'h0, 32'h1111_1111, 99, stalls, strb, be, wdat, ma);
    chk("to_stall", 32'(stalls), 32'd4);
    chk("to_strobe", 32'(strb), 32'd4);
    chk("to_busError", 32'(busError), 32'h1);
    chk("to_readData", readData, 32'h0);
    memAck = 1'b1;
    memReadData = 32'h7777_7777;
    tick();
    memAck = 1'b0;
    chk("to_err_pulse", 32'(busError), 32'h0);
    chk("late_ack_data", readData, 32'h0);
    chk("late_ack_strb", {30'd0, memRead, memWrite}, 32'h0);

    xact(READ, 32'h0000_0200, 32'h0, 32'h0BAD_F00D, 1, stalls, strb, be, wdat, ma);
    chk("rd2_data", readData, 32'h0BAD_F00D);
    chk("rd2_stall", 32'(stalls), 32'd2);

    transactionControl = WRITE_DWORD;
    address = 32'h0000_0300;
    writeData = 32'h5555_AAAA;
    tick();
    chk("rst_mid_wr_on", 32'(memWrite), 32'h1);
    tick();
    reset = 1'b1;
    #1;
    chk("rst_mid_wr_off", 32'(memWrite), 32'h0);
    chk("rst_mid_err", 32'(busError), 32'h0);
    chk("rst_mid_rdata", readData, 32'h0);
    chk("rst_mid_idle", 32'(stall), 32'h1);
    transactionControl = NO_OP;
    #1;
    chk("rst_mid_nostall", 32'(stall), 32'h0);
    tick();
    reset = 1'b0;
    tick();
    xact(READ, 32'h0000_0400, 32'h0, 32'hCAFE_0001, 0, stalls, strb, be, wdat, ma);
    chk("post_rst_rd", readData, 32'hCAFE_0001);
    chk("post_rst_addr", 32'(ma), 32'h100);

    transactionControl = WRITE_DWORD;
    address = 32'h0000_0020;
    writeData = 32'hCAFE_BABE;
    #1 chk("b2b_c0_stall", 32'(stall), 32'h1);
    tick();
    memAck = 1'b1;
    chk("b2b_wr_strobe", {30'd0, memRead, memWrite}, 32'h1);
    chk("b2b_wr_data", memWriteData, 32'hCAFE_BABE);
    chk("b2b_wr_be", 32'(memByteEnable), 32'hF);
    #1 chk("b2b_wr_exit", 32'(stall), 32'h0);
    transactionControl = READ;
    address = 32'h0000_0024;
    memReadData = 32'h1357_9BDF;
    tick();
    memAck = 1'b0;
    chk("b2b_gap_strb", {30'd0, memRead, memWrite}, 32'h0);
    #1 chk("b2b_rd_accept", 32'(stall), 32'h1);
    tick();
    memAck = 1'b1;
    chk("b2b_rd_strobe", {30'd0, memRead, memWrite}, 32'h2);
    chk("b2b_rd_addr", 32'(memAddress), 32'h9);
    #1 chk("b2b_rd_exit", 32'(stall), 32'h0);
    transactionControl = NO_OP;
    tick();
    memAck = 1'b0;
    chk("b2b_rd_data", readData, 32'h1357_9BDF);
    chk("b2b_err", 32'(busError), 32'h0);
    tick();
    chk("b2b_no_dup", {30'd0, memRead, memWrite}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
